// File: rtl/gen_pipe_rx.sv
// rtl/gen_pipe_rx.sv - credit-returning receive buffer for a non-stallable valid-only pipe
//
// Purpose: absorbs words from an upstream pipe that cannot be back-pressured,
// presents them first-word fall-through to a ready/valid consumer, and returns
// one credit pulse per word consumed. Words arriving while full with no pop
// are dropped and flagged by a sticky overflow bit.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   dat_in   in   [DAT_W] upstream data
//   vld_in   in   upstream valid (no back-pressure)
//   dat_out  out  [DAT_W] head-of-buffer data (0 when empty)
//   vld_out  out  buffer non-empty
//   rdy_in   in   downstream ready
//   crd_ret  out  one-cycle pulse at the edge after each pop
//   cnt      out  [$clog2(DEPTH+1)] occupancy
//   ovf      out  sticky overflow flag
//   ovf_cnt  out  [8] saturating drop count (only with GEN_PIPE_RX_OVF_CNT_EN)
//
// Build option: define GEN_PIPE_RX_OVF_CNT_EN to add the ovf_cnt port and counter.

module gen_pipe_rx #(
  parameter int DEPTH = 4,
  parameter int DAT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DAT_W-1:0]           dat_in,
  input  logic                       vld_in,
  output logic [DAT_W-1:0]           dat_out,
  output logic                       vld_out,
  input  logic                       rdy_in,
  output logic                       crd_ret,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output logic                       ovf
`ifdef GEN_PIPE_RX_OVF_CNT_EN
  ,
  output logic [7:0]                 ovf_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DAT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic full;
  logic push;
  logic pop;
  logic drop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign vld_out = (cnt != '0);
  // Output is read straight from storage; forced to 0 when empty so the
  // reset/empty value is defined without resetting the array itself.
  assign dat_out = vld_out ? mem[rd_ptr] : '0;

  assign pop  = vld_out && rdy_in;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign push = vld_in && (!full || pop);
  assign drop = vld_in && full && !pop;

  // Storage needs no reset: entries are only visible once counted in cnt.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= dat_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      crd_ret <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally at DEPTH-1.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      crd_ret <= pop;
      if (drop) ovf <= 1'b1;
    end
  end

`ifdef GEN_PIPE_RX_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (drop && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gen_pipe_rx.sv
// tb/tb_gen_pipe_rx.sv - self-checking bench for gen_pipe_rx

module tb_gen_pipe_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] dat_in;
  logic       vld_in;
  logic [3:0] dat_out;
  logic       vld_out;
  logic       rdy_in;
  logic       crd_ret;
  logic [2:0] cnt;
  logic       ovf;
`ifdef GEN_PIPE_RX_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  always #5 clk = ~clk;

  gen_pipe_rx #(.DEPTH(4), .DAT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dat_in  (dat_in),
    .vld_in  (vld_in),
    .dat_out (dat_out),
    .vld_out (vld_out),
    .rdy_in  (rdy_in),
    .crd_ret (crd_ret),
    .cnt     (cnt),
    .ovf     (ovf)
`ifdef GEN_PIPE_RX_OVF_CNT_EN
    ,
    .ovf_cnt (ovf_cnt)
`endif
  );

  typedef struct {
    logic       rst_n;
    logic       vi;
    logic [3:0] di;
    logic       ri;
    logic       exp_vo;
    logic [3:0] exp_dat;
    logic [2:0] exp_cnt;
    logic       exp_crd;
    logic       exp_ovf;
  } vec_t;

  localparam int NVEC = 26;
  vec_t tbl [NVEC];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic drive(input logic r, input logic v, input logic [3:0] d, input logic rd);
    rst_n  = r;
    vld_in = v;
    dat_in = d;
    rdy_in = rd;
  endtask

  initial begin
    int q [$];
    int mcnt;
    int crd_seen;
    int pushed;
    int cyc;

    //               rst vi di    ri   vo dat   cnt crd ovf
    tbl[0]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 3'd1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 4'h2, 3'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 4'h3, 3'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 3'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 4'hA, 3'd1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 4'hB, 1'b0, 1'b1, 4'hA, 3'd2, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 4'hC, 1'b0, 1'b1, 4'hA, 3'd3, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 4'hD, 1'b0, 1'b1, 4'hA, 3'd4, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 4'hE, 1'b0, 1'b1, 4'hA, 3'd4, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'hA, 3'd4, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 4'hB, 3'd4, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'hC, 3'd3, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 4'h7, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 4'h1, 3'd1, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 4'h2, 1'b0, 1'b1, 4'h1, 3'd2, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 4'h1, 3'd3, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 4'h4, 1'b0, 1'b1, 4'h1, 3'd4, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 4'h2, 3'd4, 1'b1, 1'b0};
    tbl[21] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 3'd3, 1'b1, 1'b0};
    tbl[22] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h4, 3'd2, 1'b1, 1'b0};
    tbl[23] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h5, 3'd1, 1'b1, 1'b0};
    tbl[24] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 3'd0, 1'b1, 1'b0};
    tbl[25] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0};

    drive(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].rst_n, tbl[i].vi, tbl[i].di, tbl[i].ri);
      @(negedge clk);
      chk($sformatf("v%0d_vld_out", i), 32'(vld_out), 32'(tbl[i].exp_vo));
      chk($sformatf("v%0d_dat_out", i), 32'(dat_out), 32'(tbl[i].exp_dat));
      chk($sformatf("v%0d_cnt", i),     32'(cnt),     32'(tbl[i].exp_cnt));
      chk($sformatf("v%0d_crd_ret", i), 32'(crd_ret), 32'(tbl[i].exp_crd));
      chk($sformatf("v%0d_ovf", i),     32'(ovf),     32'(tbl[i].exp_ovf));
    end

    // Stream 10 words, one every other cycle, with rdy_in alternating 1,0.
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    mcnt = 0; crd_seen = 0; pushed = 0; cyc = 0;
    while ((pushed < 10 || mcnt > 0) && cyc < 100) begin
      logic v, r, pop_m;
      logic [3:0] d;
      v = (pushed < 10) && (cyc % 2 == 0);
      d = 4'((pushed * 3 + 5) & 15);
      r = (cyc % 2 == 0);
      drive(1'b1, v, d, r);
      #1;
      chk($sformatf("s%0d_vld_out", cyc), 32'(vld_out), 32'(mcnt > 0));
      pop_m = (mcnt > 0) && r;
      if (pop_m) begin
        chk($sformatf("s%0d_dat_out", cyc), 32'(dat_out), 32'(q[0]));
        void'(q.pop_front());
        mcnt--;
      end
      if (v) begin
        q.push_back(int'(d));
        mcnt++;
        pushed++;
      end
      @(negedge clk);
      if (crd_ret) crd_seen++;
      chk($sformatf("s%0d_crd_ret", cyc), 32'(crd_ret), 32'(pop_m));
      cyc++;
    end
    chk("stream_done_in_budget", 32'(cyc < 100), 32'd1);
    drive(1'b1, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    chk("stream_crd_total", 32'(crd_seen), 32'd10);
    chk("stream_cnt_end", 32'(cnt), 32'd0);
    chk("stream_ovf", 32'(ovf), 32'd0);

    // Overflow: fill, then 300 drops.
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 4'(i + 8), 1'b0);
      @(negedge clk);
    end
    drive(1'b1, 1'b1, 4'h3, 1'b0);
    @(negedge clk);
    chk("drop1_ovf", 32'(ovf), 32'd1);
    chk("drop1_cnt", 32'(cnt), 32'd4);
    chk("drop1_dat_out", 32'(dat_out), 32'h8);
`ifdef GEN_PIPE_RX_OVF_CNT_EN
    chk("drop1_ovf_cnt", 32'(ovf_cnt), 32'd1);
`endif
    for (int i = 1; i < 300; i++) begin
      @(negedge clk);
    end
    chk("drop300_cnt", 32'(cnt), 32'd4);
    chk("drop300_ovf", 32'(ovf), 32'd1);
`ifdef GEN_PIPE_RX_OVF_CNT_EN
    chk("drop300_ovf_cnt", 32'(ovf_cnt), 32'd255);
`endif
    // Drain and confirm the dropped words never entered the buffer.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 4'h0, 1'b1);
      #1;
      chk($sformatf("drain%0d_dat_out", i), 32'(dat_out), 32'(i + 8));
      @(negedge clk);
    end
    chk("drain_cnt", 32'(cnt), 32'd0);
    chk("drain_vld_out", 32'(vld_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gen_pipe_rx.md
GEN_PIPE_RX -- requirements
Module: gen_pipe_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, buffer entries; a power of 2 and >=2.
REQ-002 SHALL have parameter DAT_W, default 4, data width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port dat_in  input  DAT_W  data from a non-stallable valid-only pipe.
REQ-006 SHALL have port vld_in  input  1  dat_in valid; cannot be back-pressured.
REQ-007 SHALL have port dat_out  output  DAT_W  head-of-buffer data.
REQ-008 SHALL have port vld_out  output  1  dat_out valid.
REQ-009 SHALL have port rdy_in  input  1  downstream ready.
REQ-010 SHALL have port crd_ret  output  1  one-cycle credit-return pulse per entry popped.
REQ-011 SHALL have port cnt  output  $clog2(DEPTH+1)  current occupancy.
REQ-012 SHALL have port ovf  output  1  sticky overflow flag.

Function
REQ-013 SHALL push dat_in into the buffer at a rising edge when vld_in=1 and the buffer is not full, or when it is full and a pop occurs in the same cycle.
REQ-014 SHALL pop the head entry at a rising edge when vld_out=1 and rdy_in=1.
REQ-015 SHALL drive vld_out=1 iff cnt!=0; dat_out SHALL be the oldest stored entry (first-word fall-through from registers, no combinational path from dat_in).
REQ-016 SHALL give latency of exactly 1 cycle: a push at edge N makes the word visible at dat_out after edge N, provided older entries have drained.
REQ-017 SHALL keep dat_out and vld_out stable while vld_out=1 and rdy_in=0.
REQ-018 SHALL update cnt as +1 on push-only, -1 on pop-only, and unchanged on simultaneous push and pop or on neither.
REQ-019 SHALL implement read/write pointers that wrap from DEPTH-1 to 0 without gaps.
REQ-020 SHALL drop dat_in when vld_in=1, cnt=DEPTH and there is no pop that cycle; it SHALL then set ovf=1, which holds until reset.
REQ-021 SHALL NOT, on a dropped word, change buffer contents, pointers or cnt.
REQ-022 SHALL assert crd_ret for exactly one cycle, at the edge after each pop; back-to-back pops SHALL give back-to-back pulses.
REQ-023 SHALL treat a pop attempt when empty (rdy_in=1, vld_out=0) as a no-op.
REQ-024 SHALL allow no push bypass when empty: vld_out stays 0 in the cycle where vld_in first rises.

Reset
REQ-025 SHALL, while rst_n=0 at an edge, clear pointers, cnt=0, vld_out=0, dat_out=0, crd_ret=0, ovf=0 and the overflow counter to 0.
REQ-026 SHALL give reset priority over a simultaneous push or pop; in-flight entries are discarded and no crd_ret is issued for them.
REQ-027 SHALL accept a push on the first edge after rst_n returns to 1.

Configuration
REQ-028 SHALL, with macro GEN_PIPE_RX_OVF_CNT_EN defined, add output ovf_cnt (8 bits) counting dropped words and saturating at 255.
REQ-029 SHALL, without GEN_PIPE_RX_OVF_CNT_EN, have no ovf_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-030 SHALL cover: DEPTH=4, push 0x1,0x2,0x3 on consecutive cycles with rdy_in=1 -> dat_out 0x1,0x2,0x3 each 1 cycle after its push, and crd_ret pulses 1 cycle after each pop.
REQ-031 SHALL cover: rdy_in=0, push 4 words -> cnt=4, vld_out=1, dat_out=first word held; a fifth push -> dropped, ovf=1, cnt stays 4, ovf_cnt=1 (macro on).
REQ-032 SHALL cover: full buffer, vld_in=1 and rdy_in=1 in the same cycle -> no drop, cnt stays 4, ovf stays 0, order preserved.
REQ-033 SHALL cover: stream 10 words with rdy_in toggling 1,0,1,0 -> all 10 out in order, pointers wrapped, 10 crd_ret pulses total.
REQ-034 SHALL cover: rst_n=0 for 1 cycle with cnt=3 and ovf=1 -> next cycle cnt=0, vld_out=0, ovf=0, no crd_ret.
REQ-035 SHALL cover: 300 drops with the macro defined -> ovf_cnt=255 (saturated); without the macro -> it builds with no ovf_cnt port.
